wb_decoder_n: RTL
=================

WB_DECODER_N -- requirements
Module: wb_decoder_n

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of slave ports (legal 1..8).
REQ-002 SHALL have parameter DATA_W, default 32, data width; SEL_W = DATA_W/8.
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 SHALL have parameter SLAVE_BASE, default {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000}, packed NUM_SLAVES*ADDR_W base addresses, slot 0 in LSBs.
REQ-005 SHALL have parameter SLAVE_MASK, default four copies of 32'hFF00_0000, packed NUM_SLAVES*ADDR_W compare masks.
REQ-006 SHALL have parameter TIMEOUT, default 255, max cycles a slave may take before a bus error (legal 2..65535).
REQ-007 SHALL have ports: i_Clk in 1 system clock; i_Rstn in 1 asynchronous active-low reset.
REQ-008 SHALL have master ports: i_wb_cyc in 1; i_wb_stb in 1; i_wb_we in 1; i_wb_addr in ADDR_W; i_wb_data in DATA_W; i_wb_sel in SEL_W; o_wb_stall out 1; o_wb_ack out 1; o_wb_err out 1; o_wb_data out DATA_W.
REQ-009 SHALL have slave ports: o_wbs_cyc out NUM_SLAVES; o_wbs_stb out NUM_SLAVES; o_wbs_we out 1; o_wbs_addr out ADDR_W; o_wbs_data out DATA_W; o_wbs_sel out SEL_W (shared); i_wbs_stall in NUM_SLAVES; i_wbs_ack in NUM_SLAVES; i_wbs_data in NUM_SLAVES*DATA_W.
REQ-010 SHALL have status ports: o_err_count out 8 saturating bus-error count; o_err_addr out ADDR_W address of most recent error.

Function
REQ-011 SHALL decode slot k as hit when (i_wb_addr & MASK[k]) == (BASE[k] & MASK[k]); lowest hitting index wins on overlap.
REQ-012 SHALL implement FSM IDLE, REQ, WAIT, ERR; at most one outstanding transaction; all outputs registered.
REQ-013 IDLE: o_wb_stall=0; on i_wb_cyc&i_wb_stb at edge T0, latch we/addr/data/sel and slot index; hit -> REQ, no hit -> ERR.
REQ-014 o_wb_stall SHALL be 1 in REQ, WAIT, ERR.
REQ-015 REQ: o_wbs_cyc[idx]=1, o_wbs_stb[idx]=1 from T0+1; other slots' cyc/stb 0; on !i_wbs_stall[idx] -> WAIT, unless i_wbs_ack[idx] also high, then complete per REQ-017.
REQ-016 WAIT: o_wbs_cyc[idx]=1, o_wbs_stb[idx]=0; hold until i_wbs_ack[idx].
REQ-017 On i_wbs_ack[idx] in REQ/WAIT: register slot data into o_wb_data, pulse o_wb_ack one cycle next edge, deassert slave cyc same edge, -> IDLE.
REQ-018 i_wbs_ack from non-selected slots SHALL be ignored.
REQ-019 16-bit timeout counter SHALL clear on entering REQ, increment each cycle in REQ/WAIT; when it reaches TIMEOUT without ack -> ERR, slave cyc/stb dropped same edge.
REQ-020 ERR: o_wb_err=1 exactly one cycle, o_wb_ack=0, o_err_addr <= latched address, o_err_count increments saturating at 255, -> IDLE.
REQ-021 If i_wb_cyc falls in REQ/WAIT/ERR: abort -> IDLE next edge, slave cyc/stb 0, no ack/err pulse, err count unchanged.
REQ-022 o_wb_data SHALL hold last acked data until next ack; ack and err never high together.
REQ-023 Latency: zero-stall slave acking the cycle after stb -> o_wb_ack at T0+3.

Reset
REQ-024 On i_Rstn low, asynchronously: state IDLE; o_wb_stall=0, o_wb_ack=0, o_wb_err=0, o_wb_data=0, o_wbs_cyc=0, o_wbs_stb=0, o_wbs_we=0, o_wbs_addr=0, o_wbs_data=0, o_wbs_sel=0, o_err_count=0, o_err_addr=0, timeout counter 0.
REQ-025 Reset mid-transaction SHALL drop all slave strobes immediately; no ack/err after release.

Verification
REQ-026 Read 0x0100_0010, slot 1 stall=0, acks T0+2 with 0xDEADBEEF -> o_wbs_stb[1] only at T0+1, o_wb_ack at T0+3, o_wb_data=0xDEADBEEF.
REQ-027 Write 0x0200_0004 data 0x12345678 sel 4'b0011, slot 2 stalls 3 cycles -> stb[2] held 4 cycles, o_wbs_data/sel match, single o_wb_ack.
REQ-028 Access 0x0500_0000 (no hit) -> no slave cyc, o_wb_err at T0+2 one cycle, o_err_count=1, o_err_addr=0x0500_0000.
REQ-029 TIMEOUT=8, slot 0 never acks -> slave cyc dropped and o_wb_err pulse after 8 cycles; 300 such errors -> o_err_count=255.
REQ-030 Master drops cyc in WAIT, then late slave ack -> no o_wb_ack, FSM IDLE, next transaction normal.
REQ-031 Assert i_Rstn low during REQ -> all slave cyc/stb 0 asynchronously, outputs at reset values.

Source files
------------

// File: rtl/wb_decoder_n.sv
// wb_decoder_n
// Single-master Wishbone (pipelined) address decoder fanning out to up to
// eight slaves. One transaction in flight at a time, every output registered,
// a per-transaction timeout and a saturating bus-error log.
module wb_decoder_n #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {4{32'hFF00_0000}},
  parameter int TIMEOUT    = 255,
  localparam int SEL_W     = DATA_W / 8
) (
  input  logic                         i_Clk,
  input  logic                         i_Rstn,
  // master side
  input  logic                         i_wb_cyc,
  input  logic                         i_wb_stb,
  input  logic                         i_wb_we,
  input  logic [ADDR_W-1:0]            i_wb_addr,
  input  logic [DATA_W-1:0]            i_wb_data,
  input  logic [SEL_W-1:0]             i_wb_sel,
  output logic                         o_wb_stall,
  output logic                         o_wb_ack,
  output logic                         o_wb_err,
  output logic [DATA_W-1:0]            o_wb_data,
  // slave side
  output logic [NUM_SLAVES-1:0]        o_wbs_cyc,
  output logic [NUM_SLAVES-1:0]        o_wbs_stb,
  output logic                         o_wbs_we,
  output logic [ADDR_W-1:0]            o_wbs_addr,
  output logic [DATA_W-1:0]            o_wbs_data,
  output logic [SEL_W-1:0]             o_wbs_sel,
  input  logic [NUM_SLAVES-1:0]        i_wbs_stall,
  input  logic [NUM_SLAVES-1:0]        i_wbs_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0] i_wbs_data,
  // status
  output logic [7:0]                   o_err_count,
  output logic [ADDR_W-1:0]            o_err_addr
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  // The counter value seen on the edge where it would reach TIMEOUT.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ERR
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_idx;
  logic [15:0]           r_tmo;
  logic                  r_stall;
  logic                  r_ack;
  logic                  r_err;
  logic [DATA_W-1:0]     r_rdata;
  logic [NUM_SLAVES-1:0] r_cyc;
  logic [NUM_SLAVES-1:0] r_stb;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [SEL_W-1:0]      r_sel;
  logic [7:0]            r_err_count;
  logic [ADDR_W-1:0]     r_err_addr;

  logic                  w_hit;
  logic [IDX_W-1:0]      w_hit_idx;
  logic [NUM_SLAVES-1:0] w_hit_vec;
  logic                  w_sel_ack;
  logic                  w_sel_stall;
  logic [DATA_W-1:0]     w_sel_data;

  // Address decode: scan from the top slot down so the lowest hitting slot wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_hit_vec = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((i_wb_addr & SLAVE_MASK[k*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[k*ADDR_W +: ADDR_W] & SLAVE_MASK[k*ADDR_W +: ADDR_W])) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(k);
        w_hit_vec = NUM_SLAVES'(1) << k;
      end
    end
  end

  // Only the slave latched for the current transaction is ever listened to.
  assign w_sel_ack   = i_wbs_ack[r_idx];
  assign w_sel_stall = i_wbs_stall[r_idx];
  assign w_sel_data  = i_wbs_data[int'(r_idx)*DATA_W +: DATA_W];

  // Transaction FSM: accept, strobe the slave, wait for ack/timeout, report.
  always_ff @(posedge i_Clk or negedge i_Rstn) begin
    if (!i_Rstn) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_tmo       <= '0;
      r_stall     <= 1'b0;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= '0;
      r_cyc       <= '0;
      r_stb       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_err_count <= '0;
      r_err_addr  <= '0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            r_we    <= i_wb_we;
            r_addr  <= i_wb_addr;
            r_wdata <= i_wb_data;
            r_sel   <= i_wb_sel;
            r_idx   <= w_hit_idx;
            r_tmo   <= '0;
            r_stall <= 1'b1;
            if (w_hit) begin
              r_cyc   <= w_hit_vec;
              r_stb   <= w_hit_vec;
              r_state <= ST_REQ;
            end else begin
              r_state <= ST_ERR;
            end
          end
        end

        ST_REQ, ST_WAIT: begin
          if (!i_wb_cyc) begin
            // Master gave up: release the slave quietly.
            r_cyc   <= '0;
            r_stb   <= '0;
            r_stall <= 1'b0;
            r_state <= ST_IDLE;
          end else if (w_sel_ack) begin
            r_rdata <= w_sel_data;
            r_ack   <= 1'b1;
            r_cyc   <= '0;
            r_stb   <= '0;
            r_stall <= 1'b0;
            r_state <= ST_IDLE;
          end else if (r_tmo == TMO_LAST) begin
            r_cyc   <= '0;
            r_stb   <= '0;
            r_state <= ST_ERR;
          end else begin
            r_tmo <= r_tmo + 16'd1;
            if ((r_state == ST_REQ) && !w_sel_stall) begin
              r_stb   <= '0;
              r_state <= ST_WAIT;
            end
          end
        end

        ST_ERR: begin
          r_stall <= 1'b0;
          r_state <= ST_IDLE;
          if (i_wb_cyc) begin
            r_err      <= 1'b1;
            r_err_addr <= r_addr;
            if (r_err_count != 8'hFF) begin
              r_err_count <= r_err_count + 8'd1;
            end
          end
        end

        default: begin
          r_cyc   <= '0;
          r_stb   <= '0;
          r_stall <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_wb_stall  = r_stall;
  assign o_wb_ack    = r_ack;
  assign o_wb_err    = r_err;
  assign o_wb_data   = r_rdata;
  assign o_wbs_cyc   = r_cyc;
  assign o_wbs_stb   = r_stb;
  assign o_wbs_we    = r_we;
  assign o_wbs_addr  = r_addr;
  assign o_wbs_data  = r_wdata;
  assign o_wbs_sel   = r_sel;
  assign o_err_count = r_err_count;
  assign o_err_addr  = r_err_addr;

endmodule
